// File: rtl/hazard_control_unit_if.sv
// Hazard control bundle: ID/EX/MEM hazard inputs and pipeline enable/flush outputs.
// Latency: none, this is wiring only.
// Backpressure: none here; the enables carry the stall/flush decisions to the pipeline.
// Ports: master = pipeline side driving hazard inputs; slave = hazard_control_unit.
interface hazard_control_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_ex_rd;
    logic             id_ex_MemRead;
    logic             ex_branch_taken;
    logic             ex_mem_MemAccess;
    logic             dmem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_flush;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
               id_ex_MemRead, ex_branch_taken, ex_mem_MemAccess, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_flush, mem_timeout_err, stall_cycles, flush_events
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
               id_ex_MemRead, ex_branch_taken, ex_mem_MemAccess, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_flush, mem_timeout_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush generator for the 5-stage RV32I pipeline (load-use, EX branch flush, dmem wait).
// Latency: control outputs are combinational (0 cycles); FSM, error flag and counters update on clk.
// Backpressure: a dmem wait freezes every stage up to EX/MEM and bubbles MEM/WB until dmem_ready.
// Ports: clk, rst_n (async active-low) plus hif (slave modport) carrying all hazard I/O.
module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_control_unit_if.slave  hif
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic freeze;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;
    logic branch_flush;

    // A load into x0 never produces a value, so it can never cause a stall.
    assign rs1_hit  = hif.id_uses_rs1 & (hif.id_ex_rd == hif.if_id_rs1);
    assign rs2_hit  = hif.id_uses_rs2 & (hif.id_ex_rd == hif.if_id_rs2);
    assign load_use = hif.id_ex_MemRead & (hif.id_ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    assign freeze   = hif.ex_mem_MemAccess & ~hif.dmem_ready;

    // A branch seen during a freeze stays parked in EX and is applied on release.
    assign branch_flush = ~freeze & hif.ex_branch_taken;

    // Control outputs, priority freeze > branch > load_use > normal.
    always_comb begin
        hif.pc_write     = 1'b1;
        hif.if_id_write  = 1'b1;
        hif.if_id_flush  = 1'b0;
        hif.id_ex_write  = 1'b1;
        hif.id_ex_flush  = 1'b0;
        hif.ex_mem_write = 1'b1;
        hif.mem_wb_flush = 1'b0;
        if (!rst_n) begin
            hif.pc_write     = 1'b0;
            hif.if_id_write  = 1'b0;
            hif.if_id_flush  = 1'b1;
            hif.id_ex_write  = 1'b0;
            hif.id_ex_flush  = 1'b1;
            hif.ex_mem_write = 1'b0;
            hif.mem_wb_flush = 1'b1;
        end else if (freeze) begin
            hif.pc_write     = 1'b0;
            hif.if_id_write  = 1'b0;
            hif.id_ex_write  = 1'b0;
            hif.ex_mem_write = 1'b0;
            hif.mem_wb_flush = 1'b1;
        end else if (hif.ex_branch_taken) begin
            hif.if_id_flush  = 1'b1;
            hif.id_ex_flush  = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX; the load moves on
            // so id_ex_MemRead drops next cycle and the stall lasts exactly one cycle.
            hif.pc_write     = 1'b0;
            hif.if_id_write  = 1'b0;
            hif.id_ex_flush  = 1'b1;
        end
    end

    // Memory-wait FSM and sticky timeout flag.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (freeze) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (freeze) begin
                    if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    state_d    = IDLE;
                    wait_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase
        // The flag sets on the edge that records the MEM_TIMEOUT-th wait cycle.
        if (freeze && (wait_cnt_d == 8'(MEM_TIMEOUT))) begin
            err_d = 1'b1;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!hif.pc_write && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (branch_flush && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign hif.mem_timeout_err = err_q;
    assign hif.stall_cycles    = stall_q;
    assign hif.flush_events    = flush_q;

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Stall/flush producer for the 5-stage RV32I pipeline. It generates the pipeline-register enables and bubbles that the forwarding path cannot cover.
- Covers three cases: load-use stalls, taken-branch flushes resolved in EX, and multi-cycle data-memory waits.
- Sits beside forwarding_unit and drives the write/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps a memory-wait FSM with timeout detection, plus saturating performance counters.

Parameters:
- MEM_TIMEOUT, 16, wait cycles in MEM_WAIT before mem_timeout_err sets (range 1..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_id_rs1  input  5  rs1 of the instruction in ID
- if_id_rs2  input  5  rs2 of the instruction in ID
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- id_ex_rd  input  5  destination of the instruction in EX
- id_ex_MemRead  input  1  EX instruction is a load
- ex_branch_taken  input  1  branch/jump in EX redirects PC
- ex_mem_MemAccess  input  1  MEM-stage instruction issues a load or store
- dmem_ready  input  1  data memory completes the access this cycle
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID load enable
- if_id_flush  output  1  IF/ID cleared to NOP
- id_ex_write  output  1  ID/EX load enable
- id_ex_flush  output  1  ID/EX loads a bubble (all control zero)
- ex_mem_write  output  1  EX/MEM load enable
- mem_wb_flush  output  1  MEM/WB loads a bubble
- mem_timeout_err  output  1  sticky: a memory wait reached MEM_TIMEOUT
- stall_cycles  output  CNT_W  cycles with pc_write=0 since reset
- flush_events  output  CNT_W  taken-branch flushes applied since reset

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE; wait counter, counters and mem_timeout_err clear to 0.
  - While rst_n=0: all *_write=0, if_id_flush=1, id_ex_flush=1, mem_wb_flush=1.
  - After rst_n deasserts, the first clk edge starts normal operation.
- Control outputs are combinational from the current inputs and state (zero latency). FSM and counters update on the rising edge.
- Conditions:
  - freeze = ex_mem_MemAccess & ~dmem_ready.
  - load_use = id_ex_MemRead & (id_ex_rd != 0) & ((id_uses_rs1 & id_ex_rd == if_id_rs1) | (id_uses_rs2 & id_ex_rd == if_id_rs2)).
  - A write to x0 never stalls.
- Priority: freeze > ex_branch_taken > load_use > normal.
  - freeze: pc_write, if_id_write, id_ex_write and ex_mem_write = 0; mem_wb_flush=1; all other flushes 0. A branch or load-use present in the same cycle is ignored; it stays in its stage and is handled after release.
  - ex_branch_taken: all writes=1, if_id_flush=1, id_ex_flush=1. The flush wins over a simultaneous load_use.
  - load_use: pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1, ex_mem_write=1. Exactly one bubble results, because id_ex_MemRead is 0 on the next cycle.
  - normal: all writes=1, all flushes=0.
- FSM:
  - IDLE -> MEM_WAIT when freeze; the wait counter loads 1.
  - MEM_WAIT stays while freeze, with the counter incrementing (saturating at 255).
  - When the counter reaches MEM_TIMEOUT, mem_timeout_err sets and holds until reset. The pipeline keeps waiting; there is no abort.
  - MEM_WAIT -> IDLE in the cycle dmem_ready=1 or ex_mem_MemAccess=0. Outputs are normal (non-freeze) in that cycle; the counter clears.
  - A new freeze on the cycle right after release re-enters MEM_WAIT with the counter at 1.
- Counters:
  - stall_cycles increments on every edge where pc_write=0 outside reset. This covers both freeze and load_use.
  - flush_events increments on every edge where the branch flush is applied (not during freeze).
  - Both counters saturate at all-ones; no wrap.
- Reset mid-wait: the FSM returns to IDLE immediately and the error flag clears.

Test Plan:
- Load-use with id_ex_MemRead=1, id_ex_rd=5, if_id_rs1=5, id_uses_rs1=1, for one cycle:
  - expect pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1.
  - With id_ex_MemRead=0 on the next cycle, all writes=1; stall_cycles=1.
- id_ex_rd=0 with a load, and if_id_rs1=0: expect no stall (pc_write=1, id_ex_flush=0).
- ex_branch_taken=1 in the same cycle as a load_use match:
  - expect if_id_flush=1, id_ex_flush=1, pc_write=1.
  - flush_events=1; stall_cycles unchanged.
- ex_mem_MemAccess=1, dmem_ready=0 for 3 cycles, then 1, with MEM_TIMEOUT=16:
  - expect freeze outputs (mem_wb_flush=1, all writes 0) for 3 cycles, then normal outputs.
  - stall_cycles=3; mem_timeout_err=0.
- ex_branch_taken=1 held during a 2-cycle freeze:
  - expect no flush while frozen.
  - Flush asserts in the release cycle; flush_events increments once.
- MEM_TIMEOUT=4 and dmem_ready low for 6 cycles:
  - mem_timeout_err rises after the 4th wait cycle and stays 1 after release.
  - Pulsing rst_n low mid-wait clears it asynchronously, and all writes=0 while reset is low.
